gemm_fixed_weights_each_cycle: RTL and testbench
================================================

Name: gemm_fixed_weights_each_cycle

Overview:
- Weight-stationary SA_SIZE x SA_SIZE systolic-array GEMM engine.
- Accepts one activation vector every cycle and emits one matrix-vector product every cycle after a fixed pipeline latency.
- Weights are held stationary in the array; only activations stream.
- Sits in the datapath as a fully pipelined, no-backpressure matrix-vector multiplier.

Parameters:
- SA_SIZE, 4, array dimension N; vector length and matrix is N x N.
- WEIGHT_ACTIVATION_SIZE, 8, bit width W of weights, activations, partial sums and outputs.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- resetn, input, 1, asynchronous active-low reset.
- activation_inputs, input, W x [SA_SIZE] unpacked array, activation vector sampled every rising edge.
- activation_outputs, output, W x [SA_SIZE] unpacked array, result vector.
- output_valid, output, 1, high when activation_outputs holds a valid product.

Behaviour:
- Function: out[i] = sum over j of in[j]*weights_reg[j][i], for i, j in 0..N-1. Input element j multiplies weight row j; column i produces out[i].
- Arithmetic: unsigned; every product and accumulation is truncated modulo 2^W. No saturation and no widening.
- Latency: exactly 2*SA_SIZE rising edges from sampling an input vector to that vector's result appearing on activation_outputs.
- Throughput: one vector per cycle, no stalls, no input handshake.
- Pipeline structure:
  - Input row j is skewed by j register stages.
  - Each PE registers its activation (passed right) and its partial sum (psum_in + act*weight, passed down).
  - Column outputs are deskewed so all N results align.
- Weights: held in weights_reg[SA_SIZE][SA_SIZE] inside sub-instance u_SA; this hierarchical name is fixed for verification.
  - Base build: weights_reg has no reset and no write path; it keeps its initial/preloaded value.
  - Benches preload it hierarchically; formal treats it as free-but-constant.
- Reset (async assert, sync deassert via the flops' normal clocking):
  - All pipeline registers clear to 0; activation_outputs = 0; output_valid = 0.
  - A valid counter clears to 0. weights_reg is unaffected.
- output_valid:
  - Counter counts rising edges with resetn high, saturating at 2*SA_SIZE.
  - output_valid = (counter == 2*SA_SIZE), so it rises at the 2*SA_SIZE-th edge after reset release.
  - When it rises, out reflects the input sampled at the first post-reset edge.
  - Once high it stays high until the next reset.
  - Required property: !output_valid implies output_valid exactly 2*SA_SIZE cycles later.
- Reset mid-operation: pipeline flushed, output_valid drops immediately, full 2*SA_SIZE refill required.
- Outputs while output_valid=0 are don't-care; they are derived from zeroed or partially filled pipeline.

Optional Feature:
- Macro: GEMM_WEIGHT_LOAD_EN.
- When defined, adds ports:
  - weight_load (input, 1)
  - weight_row (input, clog2(SA_SIZE))
  - weight_data (input, W x [SA_SIZE])
- On a rising edge with weight_load=1, weights_reg[weight_row][i] <= weight_data[i] for all i.
- A load takes effect for inputs sampled on later edges; in-flight vectors may see mixed weights and are don't-care.
- weights_reg resets to 0 when the feature is enabled.
- Without the macro: no ports, no write path, behaviour as the base build.

Decomposition:
- Shared package gemm_pkg:
  - typedef for a W-bit element;
  - a latency constant function returning 2*SA_SIZE;
  - clog2 helper for weight_row.
- One natural sub-module: gemm_sa_core, instantiated as u_SA. It owns weights_reg, the PE grid, and the input skew and output deskew registers.
- The top level holds the valid counter and the port wiring.

Test Plan:
- Reset then hold: resetn low 3 cycles, release -> output_valid=0 for 2*SA_SIZE-1 edges, 1 at edge 2*SA_SIZE, and stays 1 for 50 cycles.
- N=2, weights [[3,0],[0,2]], input (2,5) on first post-reset edge -> at valid rise out=(6,10).
- N=2, same weights, inputs (2,5) then (3,2) on consecutive edges -> out=(6,10) then (9,4) on consecutive valid cycles.
- N=4, W=8, all weights 255, inputs all 255 every cycle -> out[i] = (4*65025) mod 256 = 4 on every valid cycle.
- Random back-to-back vectors, N=4 -> every valid cycle, out matches the golden modulo-2^W product of the input sampled 2*SA_SIZE edges earlier.
- Assert resetn mid-stream -> output_valid and outputs 0 immediately; valid returns exactly 2*SA_SIZE edges after release. With GEMM_WEIGHT_LOAD_EN, load row 1=(7,1) then input (0,1) -> out=(7,1).

Source files
------------

// File: rtl/gemm_pkg.sv
// Shared types and helpers for the weight-stationary GEMM engine.
package gemm_pkg;

    localparam int unsigned DEFAULT_SA_SIZE = 4;
    localparam int unsigned DEFAULT_ELEM_W  = 8;

    typedef logic [DEFAULT_ELEM_W-1:0] elem_t;

    // Edges from sampling an input vector to its result appearing on the outputs.
    function automatic int unsigned gemm_latency(input int unsigned sa_size);
        return 2 * sa_size;
    endfunction

    // Width of a row index; never zero so a 1x1 array still has a legal port.
    function automatic int unsigned gemm_clog2(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gemm_sa_core.sv
// Systolic array core: weight store, input skew, PE grid and output deskew.
// Optional runtime weight load port under GEMM_WEIGHT_LOAD_EN.
module gemm_sa_core
    import gemm_pkg::*;
#(
    parameter int unsigned SA_SIZE                = 4,
    parameter int unsigned WEIGHT_ACTIVATION_SIZE = 8
) (
    input  logic                              clk,
    input  logic                              resetn,
`ifdef GEMM_WEIGHT_LOAD_EN
    input  logic                              weight_load,
    input  logic [gemm_clog2(SA_SIZE)-1:0]    weight_row,
    input  logic [WEIGHT_ACTIVATION_SIZE-1:0] weight_data [SA_SIZE],
`endif
    input  logic [WEIGHT_ACTIVATION_SIZE-1:0] activation_inputs [SA_SIZE],
    output logic [WEIGHT_ACTIVATION_SIZE-1:0] activation_outputs [SA_SIZE]
);

    localparam int N = SA_SIZE;
    localparam int W = WEIGHT_ACTIVATION_SIZE;

    logic [W-1:0] weights_reg [N][N];

`ifdef GEMM_WEIGHT_LOAD_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    weights_reg[r][c] <= '0;
                end
            end
        end else if (weight_load) begin
            for (int c = 0; c < N; c++) begin
                weights_reg[weight_row][c] <= weight_data[c];
            end
        end
    end
`else
    // No write path: the array keeps whatever value was preloaded into it.
    always_ff @(posedge clk) begin
        weights_reg <= weights_reg;
    end
`endif

    // Row j enters the grid j cycles late so it meets the partial sum from row j-1.
    logic [W-1:0] row_act [N];

    for (genvar j = 0; j < N; j++) begin : g_skew
        if (j == 0) begin : g_direct
            assign row_act[j] = activation_inputs[j];
        end else begin : g_chain
            logic [W-1:0] skew_q [j];
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    for (int k = 0; k < j; k++) begin
                        skew_q[k] <= '0;
                    end
                end else begin
                    skew_q[0] <= activation_inputs[j];
                    for (int k = 1; k < j; k++) begin
                        skew_q[k] <= skew_q[k-1];
                    end
                end
            end
            assign row_act[j] = skew_q[j-1];
        end
    end

    logic [W-1:0] act_w  [N][N];
    logic [W-1:0] psum_w [N][N];

    for (genvar j = 0; j < N; j++) begin : g_row
        for (genvar i = 0; i < N; i++) begin : g_pe
            logic [W-1:0] act_in;
            logic [W-1:0] psum_in;
            logic [W-1:0] act_q;
            logic [W-1:0] psum_q;

            if (i == 0) begin : g_left
                assign act_in = row_act[j];
            end else begin : g_inner
                assign act_in = act_w[j][i-1];
            end

            if (j == 0) begin : g_top
                assign psum_in = '0;
            end else begin : g_below
                assign psum_in = psum_w[j-1][i];
            end

            // Product and sum are both truncated to W bits by the assignment width.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    act_q  <= '0;
                    psum_q <= '0;
                end else begin
                    act_q  <= act_in;
                    psum_q <= psum_in + act_in * weights_reg[j][i];
                end
            end

            assign act_w[j][i]  = act_q;
            assign psum_w[j][i] = psum_q;
        end
    end

    // Column i finishes i cycles after column 0; N-i stages realign them and register the output.
    for (genvar i = 0; i < N; i++) begin : g_deskew
        localparam int DEPTH = N - i;
        logic [W-1:0] dsk_q [DEPTH];
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                for (int k = 0; k < DEPTH; k++) begin
                    dsk_q[k] <= '0;
                end
            end else begin
                dsk_q[0] <= psum_w[N-1][i];
                for (int k = 1; k < DEPTH; k++) begin
                    dsk_q[k] <= dsk_q[k-1];
                end
            end
        end
        assign activation_outputs[i] = dsk_q[DEPTH-1];
    end

endmodule

// File: rtl/gemm_fixed_weights_each_cycle.sv
// Fully pipelined matrix-vector multiplier top: valid tracking around the systolic core.
// Runtime weight loading is added when GEMM_WEIGHT_LOAD_EN is defined.
module gemm_fixed_weights_each_cycle
    import gemm_pkg::*;
#(
    parameter int unsigned SA_SIZE                = 4,
    parameter int unsigned WEIGHT_ACTIVATION_SIZE = 8
) (
    input  logic                              clk,
    input  logic                              resetn,
`ifdef GEMM_WEIGHT_LOAD_EN
    input  logic                              weight_load,
    input  logic [gemm_clog2(SA_SIZE)-1:0]    weight_row,
    input  logic [WEIGHT_ACTIVATION_SIZE-1:0] weight_data [SA_SIZE],
`endif
    input  logic [WEIGHT_ACTIVATION_SIZE-1:0] activation_inputs [SA_SIZE],
    output logic [WEIGHT_ACTIVATION_SIZE-1:0] activation_outputs [SA_SIZE],
    output logic                              output_valid
);

    localparam int unsigned LATENCY = gemm_latency(SA_SIZE);
    localparam int unsigned CNT_W   = $clog2(LATENCY + 1);

    logic [CNT_W-1:0] valid_cnt_q;

    // Saturates at LATENCY, the edge at which the first post-reset vector emerges.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_cnt_q <= '0;
        end else if (valid_cnt_q != CNT_W'(LATENCY)) begin
            valid_cnt_q <= valid_cnt_q + 1'b1;
        end
    end

    assign output_valid = (valid_cnt_q == CNT_W'(LATENCY));

    gemm_sa_core #(
        .SA_SIZE               (SA_SIZE),
        .WEIGHT_ACTIVATION_SIZE(WEIGHT_ACTIVATION_SIZE)
    ) u_SA (
        .clk               (clk),
        .resetn            (resetn),
`ifdef GEMM_WEIGHT_LOAD_EN
        .weight_load       (weight_load),
        .weight_row        (weight_row),
        .weight_data       (weight_data),
`endif
        .activation_inputs (activation_inputs),
        .activation_outputs(activation_outputs)
    );

endmodule

// File: tb/tb_gemm_fixed_weights_each_cycle.sv
// Directed bench for gemm_fixed_weights_each_cycle with a 2x2 and a 4x4 instance.
// Exercises the GEMM_WEIGHT_LOAD_EN load path when that macro is defined.
module tb_gemm_fixed_weights_each_cycle;
    import gemm_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic  resetn;
    elem_t in2  [2];
    elem_t out2 [2];
    logic  v2;
    elem_t in4  [4];
    elem_t out4 [4];
    logic  v4;

`ifdef GEMM_WEIGHT_LOAD_EN
    logic       wl2;
    logic [0:0] wr2;
    elem_t      wd2 [2];
    logic       wl4;
    logic [1:0] wr4;
    elem_t      wd4 [4];
`endif

    elem_t w2 [2][2];
    elem_t w4 [4][4];
    elem_t h2 [41][2];
    elem_t h4 [41][4];

    int n_tests = 0;
    int n_fail  = 0;

    gemm_fixed_weights_each_cycle #(
        .SA_SIZE               (2),
        .WEIGHT_ACTIVATION_SIZE(8)
    ) u_dut2 (
        .clk               (clk),
        .resetn            (resetn),
`ifdef GEMM_WEIGHT_LOAD_EN
        .weight_load       (wl2),
        .weight_row        (wr2),
        .weight_data       (wd2),
`endif
        .activation_inputs (in2),
        .activation_outputs(out2),
        .output_valid      (v2)
    );

    gemm_fixed_weights_each_cycle #(
        .SA_SIZE               (4),
        .WEIGHT_ACTIVATION_SIZE(8)
    ) u_dut4 (
        .clk               (clk),
        .resetn            (resetn),
`ifdef GEMM_WEIGHT_LOAD_EN
        .weight_load       (wl4),
        .weight_row        (wr4),
        .weight_data       (wd4),
`endif
        .activation_inputs (in4),
        .activation_outputs(out4),
        .output_valid      (v4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Modulo-256 golden dot products against the bench's own weight copies.
    function automatic elem_t ref2(input int s, input int i);
        elem_t acc = '0;
        for (int j = 0; j < 2; j++) acc = acc + h2[s][j] * w2[j][i];
        return acc;
    endfunction

    function automatic elem_t ref4(input int s, input int i);
        elem_t acc = '0;
        for (int j = 0; j < 4; j++) acc = acc + h4[s][j] * w4[j][i];
        return acc;
    endfunction

    task automatic preload();
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < 2; i++) u_dut2.u_SA.weights_reg[j][i] = w2[j][i];
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++) u_dut4.u_SA.weights_reg[j][i] = w4[j][i];
    endtask

    initial begin
        resetn = 1'b0;
        in2 = '{8'd0, 8'd0};
        in4 = '{8'd0, 8'd0, 8'd0, 8'd0};
`ifdef GEMM_WEIGHT_LOAD_EN
        wl2 = 1'b0; wr2 = '0; wd2 = '{8'd0, 8'd0};
        wl4 = 1'b0; wr4 = '0; wd4 = '{8'd0, 8'd0, 8'd0, 8'd0};
`endif
        w2 = '{'{8'd3, 8'd0}, '{8'd0, 8'd2}};
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++) w4[j][i] = 8'd255;

        // Reset held for three edges.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_v2", {31'd0, v2}, 0);
        chk("rst_v4", {31'd0, v4}, 0);
        chk("rst_out2_0", out2[0], 0);
        chk("rst_out4_3", out4[3], 0);

        // Release, preload weights, first vector lands on the first post-reset edge.
        resetn = 1'b1;
        preload();
        in2 = '{8'd2, 8'd5};
        in4 = '{8'd255, 8'd255, 8'd255, 8'd255};
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v2_e%0d", e), {31'd0, v2}, (e >= 4) ? 1 : 0);
            chk($sformatf("v4_e%0d", e), {31'd0, v4}, (e >= 8) ? 1 : 0);
            if (e == 4) begin
                chk("n2_first_0", out2[0], 6);
                chk("n2_first_1", out2[1], 10);
            end
            if (e == 5) begin
                chk("n2_second_0", out2[0], 9);
                chk("n2_second_1", out2[1], 4);
            end
            if (e >= 8) begin
                for (int i = 0; i < 4; i++) chk($sformatf("n4_all255_e%0d_%0d", e, i), out4[i], 4);
            end
            in2 = (e == 1) ? '{8'd3, 8'd2} : '{8'd0, 8'd0};
        end

        // Mid-stream reset: outputs and valid clear without waiting for an edge.
        resetn = 1'b0;
        #1;
        chk("mid_v2", {31'd0, v2}, 0);
        chk("mid_v4", {31'd0, v4}, 0);
        for (int i = 0; i < 4; i++) chk($sformatf("mid_out4_%0d", i), out4[i], 0);
        chk("mid_out2_1", out2[1], 0);
        repeat (2) @(negedge clk);

        // Distinct weights for the random back-to-back phase.
        w2 = '{'{8'd7, 8'd200}, '{8'd19, 8'd3}};
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++) w4[j][i] = 8'(16 * j + 3 * i + 1);
        resetn = 1'b1;
        preload();
        for (int e = 1; e <= 40; e++) begin
            for (int i = 0; i < 4; i++) begin
                in4[i] = 8'($urandom_range(0, 255));
                h4[e][i] = in4[i];
            end
            for (int i = 0; i < 2; i++) begin
                in2[i] = 8'($urandom_range(0, 255));
                h2[e][i] = in2[i];
            end
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("rv4_e%0d", e), {31'd0, v4}, (e >= 8) ? 1 : 0);
            chk($sformatf("rv2_e%0d", e), {31'd0, v2}, (e >= 4) ? 1 : 0);
            if (e >= 8) begin
                for (int i = 0; i < 4; i++)
                    chk($sformatf("rnd4_e%0d_%0d", e, i), out4[i], ref4(e - 7, i));
            end
            if (e >= 4) begin
                for (int i = 0; i < 2; i++)
                    chk($sformatf("rnd2_e%0d_%0d", e, i), out2[i], ref2(e - 3, i));
            end
        end

`ifdef GEMM_WEIGHT_LOAD_EN
        // Load row 1 = (7,1), then (0,1) selects exactly that row.
        wl2 = 1'b1;
        wr2 = 1'b1;
        wd2 = '{8'd7, 8'd1};
        @(posedge clk);
        @(negedge clk);
        wl2 = 1'b0;
        in2 = '{8'd0, 8'd1};
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("load_out2_0", out2[0], 7);
        chk("load_out2_1", out2[1], 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
